// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: exhaustive-pattern BIST controller for the C17 netlist.
// Steps a 5-bit pattern onto pi0..pi4, folds po0/po1 into an 8-bit MISR,
// then compares the final signature against GOLDEN_SIG and pulses done.
module c17_bist_ctrl #(
  parameter int         N_PATTERNS = 32,
  parameter logic [7:0] GOLDEN_SIG = 8'h00,
  parameter logic [7:0] MISR_SEED  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  input  logic       po0,
  input  logic       po1,
  output logic       pi0,
  output logic       pi1,
  output logic       pi2,
  output logic       pi3,
  output logic       pi4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Count value at which the last pattern's response is absorbed.
  localparam logic [5:0] LAST_CNT = 6'(N_PATTERNS - 1);

  state_t     state_r, state_s;
  logic [5:0] cnt_r, cnt_s;
  logic [7:0] misr_r, misr_s;
  logic [4:0] pi_r, pi_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       pass_r, pass_s;
  logic       absorb_s;
  logic       last_s;

  // MISR step: feedback from bit 7 into taps 0,2,3,4; po0/po1 enter bits 0/1.
  function automatic logic [7:0] misr_next(input logic [7:0] m,
                                           input logic       in0,
                                           input logic       in1);
    logic [7:0] n;
    n[0] = m[7] ^ in0;
    n[1] = m[0] ^ in1;
    n[2] = m[1] ^ m[7];
    n[3] = m[2] ^ m[7];
    n[4] = m[3] ^ m[7];
    n[5] = m[4];
    n[6] = m[5];
    n[7] = m[6];
    return n;
  endfunction

  assign absorb_s = (state_r == ST_APPLY) && !hold;
  assign last_s   = absorb_s && (cnt_r == LAST_CNT);

  // State register plus all registered datapath/outputs, with sync reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      misr_r  <= MISR_SEED;
      pi_r    <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      misr_r  <= misr_s;
      pi_r    <= pi_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  // Next-state logic: IDLE -> APPLY on start, APPLY -> CHECK after last absorb.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_APPLY;
        else       state_s = ST_IDLE;
      end
      ST_APPLY: begin
        if (last_s) state_s = ST_CHECK;
        else        state_s = ST_APPLY;
      end
      ST_CHECK: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Next values for counter, MISR and the registered outputs.
  always_comb begin
    cnt_s  = cnt_r;
    misr_s = misr_r;
    pi_s   = pi_r;
    busy_s = busy_r;
    done_s = 1'b0;
    pass_s = pass_r;
    case (state_r)
      ST_IDLE: begin
        pi_s = 5'd0;
        if (start) begin
          cnt_s  = 6'd0;
          misr_s = MISR_SEED;
          pass_s = 1'b0;
          busy_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_APPLY: begin
        busy_s = 1'b1;
        if (absorb_s) begin
          misr_s = misr_next(misr_r, po0, po1);
          cnt_s  = cnt_r + 6'd1;
          // Park the pattern bus at zero once the last pattern is consumed.
          if (last_s) pi_s = 5'd0;
          else        pi_s = cnt_r[4:0] + 5'd1;
        end else begin
          pi_s = pi_r;
        end
      end
      ST_CHECK: begin
        pass_s = (misr_r == GOLDEN_SIG);
        done_s = 1'b1;
        busy_s = 1'b0;
        pi_s   = 5'd0;
      end
      default: begin
        pi_s   = 5'd0;
        busy_s = 1'b0;
      end
    endcase
  end

  assign {pi4, pi3, pi2, pi1, pi0} = pi_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = misr_r;

endmodule
